// File: rtl/cmu_ctrl_if.sv
// rtl/cmu_ctrl_if.sv - cache command/status and memory word-transfer port of the cache management unit
interface cmu_ctrl_if #(
    parameter int TAG_W = 23
);
    logic [31:0]      cache_addr;
    logic             cache_load;
    logic             cache_store;
    logic             cache_replace;
    logic             cache_invalid;
    logic [2:0]       cache_u_b_h_w;
    logic [31:0]      cache_din;
    logic             cache_hit;
    logic             cache_valid;
    logic             cache_dirty;
    logic [TAG_W-1:0] cache_tag;
    logic [31:0]      cache_dout;
    logic             mem_cs_o;
    logic             mem_we_o;
    logic [31:0]      mem_addr_o;
    logic [31:0]      mem_data_o;
    logic [31:0]      mem_data_i;
    logic             mem_ack_i;

    modport master (
        output cache_addr, cache_load, cache_store, cache_replace, cache_invalid,
               cache_u_b_h_w, cache_din, mem_cs_o, mem_we_o, mem_addr_o, mem_data_o,
        input  cache_hit, cache_valid, cache_dirty, cache_tag, cache_dout,
               mem_data_i, mem_ack_i
    );

    modport slave (
        input  cache_addr, cache_load, cache_store, cache_replace, cache_invalid,
               cache_u_b_h_w, cache_din, mem_cs_o, mem_we_o, mem_addr_o, mem_data_o,
        output cache_hit, cache_valid, cache_dirty, cache_tag, cache_dout,
               mem_data_i, mem_ack_i
    );
endinterface

// File: rtl/cmu_ctrl.sv
// rtl/cmu_ctrl.sv - cache management unit: CPU hit path, dirty victim write-back and line refill
// Commands and memory requests are decoded combinationally from the state so hits never stall.
module cmu_ctrl #(
    parameter int TAG_W     = 23,
    parameter int IDX_W     = 5,
    parameter int WORD_BITS = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en_r,
    input  logic        en_w,
    input  logic [2:0]  u_b_h_w,
    input  logic [31:0] addr_rw,
    input  logic [31:0] data_w,
    output logic [31:0] data_r,
    output logic        stall,
    cmu_ctrl_if.master  bus
);
    localparam int OFF_W = WORD_BITS + 2;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WB,
        S_FILL,
        S_WAIT
    } state_t;

    state_t               r_state;
    state_t               w_next;
    logic [WORD_BITS-1:0] r_cnt;
    logic [WORD_BITS-1:0] w_cnt_next;
    logic [TAG_W-1:0]     r_victim_tag;
    logic [TAG_W-1:0]     w_victim_next;
    logic                 w_req;
    logic                 w_last;
    logic [31:0]          w_line_addr;
    logic [31:0]          w_victim_addr;

    assign w_req         = en_r | en_w;
    assign w_last        = (r_cnt == {WORD_BITS{1'b1}});
    assign w_line_addr   = {addr_rw[31:OFF_W], r_cnt, 2'b00};
    assign w_victim_addr = {r_victim_tag, addr_rw[OFF_W+IDX_W-1:OFF_W], r_cnt, 2'b00};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_victim_tag <= '0;
        end else begin
            r_state      <= w_next;
            r_cnt        <= w_cnt_next;
            r_victim_tag <= w_victim_next;
        end
    end

    always_comb begin
        w_next            = r_state;
        w_cnt_next        = r_cnt;
        w_victim_next     = r_victim_tag;
        data_r            = '0;
        stall             = 1'b0;
        bus.cache_addr    = '0;
        bus.cache_load    = 1'b0;
        bus.cache_store   = 1'b0;
        bus.cache_replace = 1'b0;
        bus.cache_invalid = 1'b0;
        bus.cache_u_b_h_w = '0;
        bus.cache_din     = '0;
        bus.mem_cs_o      = 1'b0;
        bus.mem_we_o      = 1'b0;
        bus.mem_addr_o    = '0;
        bus.mem_data_o    = '0;

        case (r_state)
            S_IDLE: begin
                bus.cache_addr    = addr_rw;
                bus.cache_store   = en_w;
                bus.cache_load    = en_r & ~en_w;
                bus.cache_din     = data_w;
                bus.cache_u_b_h_w = u_b_h_w;
                if (w_req) begin
                    if (bus.cache_hit) begin
                        if (!en_w) begin
                            data_r = bus.cache_dout;
                        end
                    end else begin
                        stall         = 1'b1;
                        w_victim_next = bus.cache_tag;
                        w_cnt_next    = '0;
                        w_next        = (bus.cache_valid && bus.cache_dirty) ? S_WB : S_FILL;
                    end
                end
            end

            // The cache is addressed with the request line; on a miss it returns the victim-way word.
            S_WB: begin
                stall          = 1'b1;
                bus.cache_addr = w_line_addr;
                bus.mem_cs_o   = 1'b1;
                bus.mem_we_o   = 1'b1;
                bus.mem_addr_o = w_victim_addr;
                bus.mem_data_o = bus.cache_dout;
                if (bus.mem_ack_i) begin
                    w_cnt_next = r_cnt + 1'b1;
                    if (w_last) begin
                        w_next = S_FILL;
                    end
                end
            end

            S_FILL: begin
                stall          = 1'b1;
                bus.mem_cs_o   = 1'b1;
                bus.mem_addr_o = w_line_addr;
                if (bus.mem_ack_i) begin
                    bus.cache_replace = 1'b1;
                    bus.cache_addr    = w_line_addr;
                    bus.cache_din     = bus.mem_data_i;
                    bus.cache_u_b_h_w = 3'b010;
                    w_cnt_next        = r_cnt + 1'b1;
                    if (w_last) begin
                        w_next = S_WAIT;
                    end
                end
            end

            S_WAIT: begin
                stall  = 1'b1;
                w_next = S_IDLE;
            end

            default: begin
                w_next = S_IDLE;
            end
        endcase
    end
endmodule

// File: tb/tb_cmu_ctrl.sv
// tb/tb_cmu_ctrl.sv - bench for cmu_ctrl against a 2-way cache responder, word memory and flat-memory reference
module tb_cmu_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic        en_r;
    logic        en_w;
    logic [2:0]  u_b_h_w;
    logic [31:0] addr_rw;
    logic [31:0] data_w;
    logic [31:0] data_r;
    logic        stall;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    cmu_ctrl_if bus ();

    cmu_ctrl dut (
        .clk     (clk),
        .rst     (rst),
        .en_r    (en_r),
        .en_w    (en_w),
        .u_b_h_w (u_b_h_w),
        .addr_rw (addr_rw),
        .data_w  (data_w),
        .data_r  (data_r),
        .stall   (stall),
        .bus     (bus.master)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_init(input logic [31:0] a);
        return {a[15:0] ^ 16'hC0DE, ~a[15:0]};
    endfunction

    // Cache responder: 2 ways x 32 sets x 4 words; c_lru names the way to evict next
    bit        c_valid [32][2];
    bit        c_dirty [32][2];
    bit [22:0] c_tag   [32][2];
    bit [31:0] c_data  [32][2][4];
    bit        c_lru   [32];

    logic [4:0]  m_set;
    logic [22:0] m_tag;
    logic [1:0]  m_word;
    logic        m_h0, m_h1, m_way;

    assign m_set  = bus.cache_addr[8:4];
    assign m_tag  = bus.cache_addr[31:9];
    assign m_word = bus.cache_addr[3:2];

    always_comb begin
        m_h0            = c_valid[m_set][0] && (c_tag[m_set][0] == m_tag);
        m_h1            = c_valid[m_set][1] && (c_tag[m_set][1] == m_tag);
        m_way           = m_h0 ? 1'b0 : (m_h1 ? 1'b1 : c_lru[m_set]);
        bus.cache_hit   = m_h0 | m_h1;
        bus.cache_valid = c_valid[m_set][m_way];
        bus.cache_dirty = c_dirty[m_set][m_way];
        bus.cache_tag   = c_tag[m_set][m_way];
        bus.cache_dout  = c_data[m_set][m_way][m_word];
    end

    int n_repl = 0;
    always @(posedge clk) begin
        if (bus.cache_replace) begin
            n_repl <= n_repl + 1;
            c_data[m_set][c_lru[m_set]][m_word] <= bus.cache_din;
            c_tag[m_set][c_lru[m_set]]          <= m_tag;
            c_valid[m_set][c_lru[m_set]]        <= 1'b1;
            c_dirty[m_set][c_lru[m_set]]        <= 1'b0;
        end else if (bus.cache_hit && bus.cache_store) begin
            c_data[m_set][m_way][m_word] <= bus.cache_din;
            c_dirty[m_set][m_way]        <= 1'b1;
            c_lru[m_set]                 <= ~m_way;
        end else if (bus.cache_hit && bus.cache_load) begin
            c_lru[m_set] <= ~m_way;
        end
    end

    // Word memory with programmable ack latency (0 = ack in the cycle cs rises)
    bit        mem_wr  [1024];
    bit [31:0] mem_val [1024];
    int        lat  = 0;
    int        wcnt = 0;
    logic [31:0] log_addr [$];
    logic [31:0] log_data [$];
    logic        log_we   [$];

    assign bus.mem_ack_i = bus.mem_cs_o && (wcnt >= lat);

    always_comb begin
        bus.mem_data_i = mem_wr[bus.mem_addr_o[11:2]] ? mem_val[bus.mem_addr_o[11:2]]
                                                      : mem_init(bus.mem_addr_o);
    end

    always @(posedge clk) begin
        if (rst) begin
            wcnt <= 0;
        end else if (bus.mem_cs_o) begin
            if (bus.mem_ack_i) begin
                wcnt <= 0;
                log_addr.push_back(bus.mem_addr_o);
                log_we.push_back(bus.mem_we_o);
                log_data.push_back(bus.mem_we_o ? bus.mem_data_o : bus.mem_data_i);
                if (bus.mem_we_o) begin
                    mem_wr[bus.mem_addr_o[11:2]]  <= 1'b1;
                    mem_val[bus.mem_addr_o[11:2]] <= bus.mem_data_o;
                end
            end else begin
                wcnt <= wcnt + 1;
            end
        end else begin
            wcnt <= 0;
        end
    end

    // A waiting memory request must hold its address until acknowledged
    logic        p_cs, p_ack;
    logic [31:0] p_addr;
    logic        chk_hold = 1'b0;
    always @(negedge clk) begin
        if (chk_hold && bus.mem_cs_o && p_cs && !p_ack) begin
            check("mem_addr_hold", bus.mem_addr_o, p_addr);
        end
        p_cs   <= bus.mem_cs_o;
        p_ack  <= bus.mem_ack_i;
        p_addr <= bus.mem_addr_o;
    end

    // Reference: the CPU sees one flat memory regardless of caching
    bit        ref_wr  [1024];
    bit [31:0] ref_val [1024];

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        return ref_wr[a[11:2]] ? ref_val[a[11:2]] : mem_init({a[31:2], 2'b00});
    endfunction

    task automatic do_req(input logic wr, input logic [31:0] a, input logic [31:0] d,
                          output int n, output logic [31:0] rdata);
        @(negedge clk);
        en_r    = ~wr;
        en_w    = wr;
        addr_rw = a;
        data_w  = d;
        u_b_h_w = 3'b010;
        n = 0;
        #1;
        while (stall && n < 300) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (n >= 300) begin
            check("req_timeout", 32'(n), 32'd0);
        end
        rdata = data_r;
        @(posedge clk);
        #1;
        en_r = 1'b0;
        en_w = 1'b0;
    endtask

    task automatic cpu_store(input logic [31:0] a, input logic [31:0] d, output int n);
        logic [31:0] r;
        do_req(1'b1, a, d, n, r);
        ref_wr[a[11:2]]  = 1'b1;
        ref_val[a[11:2]] = d;
    endtask

    task automatic cpu_load(input string tag, input logic [31:0] a, output int n);
        logic [31:0] r;
        do_req(1'b0, a, 32'h0, n, r);
        check(tag, r, ref_rd(a));
    endtask

    task automatic expect_ops(input string tag, input int base, input logic we, input logic [31:0] a0);
        for (int i = 0; i < 4; i++) begin
            if (base + i < log_addr.size()) begin
                check({tag, "_we"}, 32'(log_we[base+i]), 32'(we));
                check({tag, "_addr"}, log_addr[base+i], a0 + 32'(4 * i));
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          n, base, r0, t, s, w;
        logic [31:0] a, d;

        rst = 1'b1; en_r = 1'b0; en_w = 1'b0; u_b_h_w = 3'b000; addr_rw = '0; data_w = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Reset and idle
        #1;
        check("rst_data_r", data_r, 32'h0);
        check("rst_cache_addr", bus.cache_addr, 32'h0);
        check("rst_cmds", {bus.cache_load, bus.cache_store, bus.cache_replace, bus.cache_invalid}, 32'h0);
        check("rst_cache_din", bus.cache_din, 32'h0);
        check("rst_ubhw", 32'(bus.cache_u_b_h_w), 32'h0);
        check("rst_mem", {bus.mem_we_o, bus.mem_addr_o[30:0]}, 32'h0);
        check("rst_mem_data", bus.mem_data_o, 32'h0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            #1;
            check("idle_mem_cs", 32'(bus.mem_cs_o), 32'h0);
            check("idle_stall", 32'(stall), 32'h0);
        end
        chk_hold = 1'b1;

        // Cold clean miss, ack each cycle
        lat = 0; base = log_addr.size(); r0 = n_repl;
        cpu_load("cold_data", 32'h20, n);
        check("cold_data_word0", ref_rd(32'h20), mem_init(32'h20));
        check("cold_latency", 32'(n), 32'd6);
        check("cold_ops", 32'(log_addr.size() - base), 32'd4);
        expect_ops("cold", base, 1'b0, 32'h20);
        check("cold_replace", 32'(n_repl - r0), 32'd4);

        // Fill 0x10 line, then it hits with no memory traffic
        cpu_load("fill10_data", 32'h10, n);
        base = log_addr.size();
        cpu_load("hit10_data", 32'h10, n);
        check("hit10_stall", 32'(n), 32'd0);
        check("hit10_ops", 32'(log_addr.size() - base), 32'd0);

        // Dirty victim write-back ahead of refill
        cpu_store(32'h204, 32'h44444444, n);
        cpu_load("set0_way1", 32'h004, n);
        base = log_addr.size();
        cpu_load("dirty_data", 32'h404, n);
        check("dirty_latency", 32'(n), 32'd10);
        check("dirty_ops", 32'(log_addr.size() - base), 32'd8);
        expect_ops("wb", base, 1'b1, 32'h200);
        expect_ops("refill", base + 4, 1'b0, 32'h400);
        if (base + 3 < log_data.size()) begin
            check("wb_word0", log_data[base], mem_init(32'h200));
            check("wb_word1", log_data[base+1], 32'h44444444);
            check("wb_word3", log_data[base+3], mem_init(32'h20C));
        end
        cpu_load("wb_reload", 32'h204, n);

        // Slow memory: 3 wait cycles per word
        lat = 3; base = log_addr.size();
        cpu_load("slow_data", 32'h30, n);
        check("slow_latency", 32'(n), 32'd18);
        check("slow_ops", 32'(log_addr.size() - base), 32'd4);
        expect_ops("slow", base, 1'b0, 32'h30);

        // Reset during the third write-back word
        lat = 2;
        cpu_store(32'h040, 32'hA0A0A0A0, n);
        cpu_store(32'h240, 32'hB1B1B1B1, n);
        @(negedge clk);
        en_r = 1'b1; addr_rw = 32'h440; u_b_h_w = 3'b010;
        n = 0;
        #1;
        while (!(bus.mem_cs_o && bus.mem_we_o && bus.mem_addr_o == 32'h48) && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("wb_word2_reached", 32'(n < 200), 32'd1);
        rst = 1'b1; en_r = 1'b0;
        @(posedge clk);
        #1;
        check("rst_wb_stall", 32'(stall), 32'h0);
        check("rst_wb_cs", 32'(bus.mem_cs_o), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1;
            check("post_rst_cs", 32'(bus.mem_cs_o), 32'h0);
        end
        cpu_load("post_rst_040", 32'h040, n);

        // Random loads/stores over a few sets and tags to force evictions
        for (int i = 0; i < 150; i++) begin
            t = $urandom_range(0, 3);
            s = $urandom_range(0, 3);
            w = $urandom_range(0, 3);
            a = 32'((t << 9) | (s << 4) | (w << 2));
            lat = $urandom_range(0, 3);
            if ($urandom_range(0, 1) == 1) begin
                d = $urandom;
                cpu_store(a, d, n);
            end else begin
                cpu_load("rand_load", a, n);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
